// File: rtl/space_inv_pkg.sv
// Shared definitions for the alien formation logic: screen widths, playfield
// limits and the march controller state encoding.
package space_inv_pkg;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  // Playfield limits; the march controller's X_MIN/X_MAX/Y_LAND default to these
  localparam logic [X_W-1:0] PF_X_MIN  = 10'd8;
  localparam logic [X_W-1:0] PF_X_MAX  = 10'd632;
  localparam logic [Y_W-1:0] PF_Y_LAND = 9'd400;

  typedef enum logic [1:0] {
    StIdle,
    StMarch,
    StDescend,
    StLanded
  } march_state_e;

  // Add two Y values, clamping at the all-ones screen coordinate
  function automatic logic [Y_W-1:0] sat_add_y(logic [Y_W-1:0] a, logic [Y_W-1:0] b);
    logic [Y_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[Y_W] ? {Y_W{1'b1}} : sum[Y_W-1:0];
  endfunction

endpackage

// File: rtl/alien_march_ctrl_if.sv
// Move-tick link between the tick counter and the march controller.
// master: march controller (consumes M1/M2, drives CntRst/CntEn).
// slave:  move-tick counter.
interface alien_march_ctrl_if;

  logic M1;
  logic M2;
  logic CntRst;
  logic CntEn;

  modport master (
    input  M1,
    input  M2,
    output CntRst,
    output CntEn
  );

  modport slave (
    output M1,
    output M2,
    input  CntRst,
    input  CntEn
  );

endinterface

// File: rtl/march_edge_chk.sv
// Combinational edge-hit test: would the next horizontal step push the
// formation past the playfield edge in the current direction?
module march_edge_chk
  import space_inv_pkg::*;
#(
  parameter logic [X_W-1:0] FORM_W = 10'd352,
  parameter logic [X_W-1:0] STEP_X = 10'd4,
  parameter logic [X_W-1:0] X_MIN  = PF_X_MIN,
  parameter logic [X_W-1:0] X_MAX  = PF_X_MAX
) (
  input  logic [X_W-1:0] pos_x,
  input  logic           dir,
  output logic           hit
);

  // One extra bit so right edge + step cannot wrap past 1023
  logic [X_W:0] right_next;
  logic [X_W:0] left_lim;

  // Right: new right edge beyond X_MAX. Left: new left edge below X_MIN.
  always_comb begin
    right_next = {1'b0, pos_x} + {1'b0, FORM_W} + {1'b0, STEP_X};
    left_lim   = {1'b0, X_MIN} + {1'b0, STEP_X};
    hit        = dir ? (right_next > {1'b0, X_MAX}) : ({1'b0, pos_x} < left_lim);
  end

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march controller. Turns move-tick strobes into formation
// steps, edge descents and landing detection, and drives the tick counter's
// restart/enable so one tick period is one formation step.
// Optional feature macro: SPEEDUP_EN (M1 also steps when few aliens remain).
module alien_march_ctrl
  import space_inv_pkg::*;
#(
  parameter logic [X_W-1:0] X_START = 10'd16,
  parameter logic [Y_W-1:0] Y_START = 9'd32,
  parameter logic [X_W-1:0] X_MIN   = PF_X_MIN,
  parameter logic [X_W-1:0] X_MAX   = PF_X_MAX,
  parameter logic [X_W-1:0] FORM_W  = 10'd352,
  parameter logic [X_W-1:0] STEP_X  = 10'd4,
  parameter logic [Y_W-1:0] STEP_Y  = 9'd16,
  parameter logic [Y_W-1:0] Y_LAND  = PF_Y_LAND,
  parameter logic [5:0]     FAST_TH = 6'd8
) (
  input  logic                      CLK,
  input  logic                      Rst_n,
  input  logic                      Start,
  input  logic                      EN,
  input  logic [5:0]                AliveCnt,
  alien_march_ctrl_if.master        tick,
  output logic [X_W-1:0]            PosX,
  output logic [Y_W-1:0]            PosY,
  output logic                      Dir,
  output logic                      StepPulse,
  output logic                      AnimFrame,
  output logic                      Landed
);

  march_state_e   state_q;
  logic [X_W-1:0] pos_x_q;
  logic [Y_W-1:0] pos_y_q;
  logic           dir_q;
  logic           cnt_rst_q;
  logic           cnt_en_q;
  logic           step_pulse_q;
  logic           anim_frame_q;
  logic           landed_q;

  logic           edge_hit;
  logic           step_ev;
  logic           will_land;

`ifdef SPEEDUP_EN
  logic fast;
  assign fast    = (AliveCnt != 6'd0) && (AliveCnt <= FAST_TH);
  assign step_ev = EN & (tick.M2 | (tick.M1 & fast));
`else
  logic unused_speedup;
  assign unused_speedup = ^{tick.M1, FAST_TH};
  assign step_ev        = EN & tick.M2;
`endif

  // Landing is judged on the Y the descent is about to produce
  assign will_land = ({1'b0, pos_y_q} + {1'b0, STEP_Y}) >= {1'b0, Y_LAND};

  march_edge_chk #(
    .FORM_W (FORM_W),
    .STEP_X (STEP_X),
    .X_MIN  (X_MIN),
    .X_MAX  (X_MAX)
  ) u_edge_chk (
    .pos_x (pos_x_q),
    .dir   (dir_q),
    .hit   (edge_hit)
  );

  // Formation FSM with position registers and registered outputs
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= StIdle;
      pos_x_q      <= X_START;
      pos_y_q      <= Y_START;
      dir_q        <= 1'b1;
      cnt_rst_q    <= 1'b1;
      cnt_en_q     <= 1'b0;
      step_pulse_q <= 1'b0;
      anim_frame_q <= 1'b0;
      landed_q     <= 1'b0;
    end else begin
      step_pulse_q <= 1'b0;
      if (Start) begin
        // Start beats everything, including landing and wave-clear
        state_q   <= StMarch;
        pos_x_q   <= X_START;
        pos_y_q   <= Y_START;
        dir_q     <= 1'b1;
        cnt_rst_q <= 1'b1;
        cnt_en_q  <= EN;
        landed_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_rst_q <= 1'b1;
            cnt_en_q  <= 1'b0;
            landed_q  <= 1'b0;
          end
          StMarch: begin
            if (!EN) begin
              // Paused: hold everything, stop the counter
              cnt_rst_q <= 1'b0;
              cnt_en_q  <= 1'b0;
            end else if (AliveCnt == 6'd0) begin
              state_q   <= StIdle;
              cnt_rst_q <= 1'b1;
              cnt_en_q  <= 1'b0;
            end else begin
              cnt_en_q  <= 1'b1;
              // Restart the period right after its end strobe
              cnt_rst_q <= tick.M2;
              if (step_ev) begin
                if (edge_hit) begin
                  state_q <= StDescend;
                end else begin
                  pos_x_q      <= dir_q ? (pos_x_q + STEP_X) : (pos_x_q - STEP_X);
                  step_pulse_q <= 1'b1;
                  anim_frame_q <= ~anim_frame_q;
                end
              end
            end
          end
          StDescend: begin
            pos_y_q      <= sat_add_y(pos_y_q, STEP_Y);
            dir_q        <= ~dir_q;
            step_pulse_q <= 1'b1;
            anim_frame_q <= ~anim_frame_q;
            if (will_land) begin
              state_q   <= StLanded;
              landed_q  <= 1'b1;
              cnt_rst_q <= 1'b1;
              cnt_en_q  <= 1'b0;
            end else begin
              state_q   <= StMarch;
              cnt_rst_q <= 1'b0;
              cnt_en_q  <= EN;
            end
          end
          StLanded: begin
            landed_q  <= 1'b1;
            cnt_rst_q <= 1'b1;
            cnt_en_q  <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tick.CntRst = cnt_rst_q;
  assign tick.CntEn  = cnt_en_q;
  assign PosX        = pos_x_q;
  assign PosY        = pos_y_q;
  assign Dir         = dir_q;
  assign StepPulse   = step_pulse_q;
  assign AnimFrame   = anim_frame_q;
  assign Landed      = landed_q;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Bench for alien_march_ctrl: a behavioural formation model checked against the
// DUT every cycle, plus literal expectations at key scenario points.
module tb_alien_march_ctrl;

  logic       CLK;
  logic       Rst_n;
  logic       Start;
  logic       EN;
  logic [5:0] AliveCnt;
  logic [9:0] PosX;
  logic [8:0] PosY;
  logic       Dir;
  logic       StepPulse;
  logic       AnimFrame;
  logic       Landed;

  alien_march_ctrl_if tick_if ();

  alien_march_ctrl dut (
    .CLK       (CLK),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .EN        (EN),
    .AliveCnt  (AliveCnt),
    .tick      (tick_if),
    .PosX      (PosX),
    .PosY      (PosY),
    .Dir       (Dir),
    .StepPulse (StepPulse),
    .AnimFrame (AnimFrame),
    .Landed    (Landed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0;
  localparam int PH_MARCH = 1;
  localparam int PH_DESC = 2;
  localparam int PH_LAND = 3;

  typedef struct {
    int x;
    int y;
    bit dir;
    int ph;
    bit rst;
    bit en;
    bit pulse;
    bit frame;
    bit landed;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.x = 16; r.y = 32; r.dir = 1'b1; r.ph = PH_IDLE;
    r.rst = 1'b1; r.en = 1'b0; r.pulse = 1'b0; r.frame = 1'b0; r.landed = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t c, input bit start, input bit en,
                                    input bit m1, input bit m2, input int alive);
    mdl_t n;
    bit   step;
    bit   fast;
    n = c;
    n.pulse = 1'b0;
`ifdef SPEEDUP_EN
    fast = (alive != 0) && (alive <= 8);
`else
    fast = 1'b0;
`endif
    if (start) begin
      n.x = 16; n.y = 32; n.dir = 1'b1; n.ph = PH_MARCH;
      n.rst = 1'b1; n.en = en; n.landed = 1'b0;
      return n;
    end
    if (c.ph == PH_IDLE) begin
      n.rst = 1'b1; n.en = 1'b0; n.landed = 1'b0;
    end else if (c.ph == PH_MARCH) begin
      if (!en) begin
        n.rst = 1'b0; n.en = 1'b0;
      end else if (alive == 0) begin
        n.ph = PH_IDLE; n.rst = 1'b1; n.en = 1'b0;
      end else begin
        n.en = 1'b1;
        n.rst = m2;
        step = m2 || (m1 && fast);
        if (step) begin
          if ((c.dir && (c.x + 352 + 4 > 632)) || (!c.dir && (c.x < 8 + 4))) begin
            n.ph = PH_DESC;
          end else begin
            n.x = c.dir ? c.x + 4 : c.x - 4;
            n.pulse = 1'b1;
            n.frame = !c.frame;
          end
        end
      end
    end else if (c.ph == PH_DESC) begin
      n.y = (c.y + 16 > 511) ? 511 : c.y + 16;
      n.dir = !c.dir;
      n.pulse = 1'b1;
      n.frame = !c.frame;
      if (c.y + 16 >= 400) begin
        n.ph = PH_LAND; n.landed = 1'b1; n.rst = 1'b1; n.en = 1'b0;
      end else begin
        n.ph = PH_MARCH; n.rst = 1'b0; n.en = en;
      end
    end else begin
      n.landed = 1'b1; n.rst = 1'b1; n.en = 1'b0;
    end
    return n;
  endfunction

  always @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) m <= mdl_reset();
    else m <= mdl_next(m, Start, EN, tick_if.M1, tick_if.M2, int'(AliveCnt));
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    chk("PosX", int'(PosX), m.x);
    chk("PosY", int'(PosY), m.y);
    chk("Dir", int'(Dir), int'(m.dir));
    chk("CntRst", int'(tick_if.CntRst), int'(m.rst));
    chk("CntEn", int'(tick_if.CntEn), int'(m.en));
    chk("StepPulse", int'(StepPulse), int'(m.pulse));
    chk("AnimFrame", int'(AnimFrame), int'(m.frame));
    chk("Landed", int'(Landed), int'(m.landed));
  end

  // ---------------- stimulus ----------------
  task automatic tick1();
    @(posedge CLK);
    #1;
  endtask

  task automatic m2_step();
    tick_if.M2 = 1'b1;
    tick1();
    tick_if.M2 = 1'b0;
  endtask

  task automatic pulse_m2();
    m2_step();
    tick1();
    tick1();
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick1();
    Start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x_exp;
    Rst_n = 1'b0; Start = 1'b0; EN = 1'b0; AliveCnt = 6'd20;
    tick_if.M1 = 1'b0; tick_if.M2 = 1'b0;
    tick1(); tick1();
    Rst_n = 1'b1;
    tick1();
    chk("idle_posx", int'(PosX), 16);
    chk("idle_cntrst", int'(tick_if.CntRst), 1);
    chk("idle_cnten", int'(tick_if.CntEn), 0);

    // Start and three plain steps
    EN = 1'b1;
    do_start();
    chk("start_cntrst", int'(tick_if.CntRst), 1);
    tick1();
    chk("march_cntrst_low", int'(tick_if.CntRst), 0);
    chk("march_cnten", int'(tick_if.CntEn), 1);
    for (int i = 0; i < 3; i++) begin
      m2_step();
      chk("step_posx", int'(PosX), 16 + 4 * (i + 1));
      chk("step_pulse", int'(StepPulse), 1);
      chk("step_cntrst", int'(tick_if.CntRst), 1);
      tick1();
      chk("step_cntrst_drop", int'(tick_if.CntRst), 0);
      tick1();
    end
    chk("anim_after3", int'(AnimFrame), 1);

    // Asynchronous reset in the middle of a march
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_posx", int'(PosX), 16);
    chk("arst_posy", int'(PosY), 32);
    chk("arst_dir", int'(Dir), 1);
    chk("arst_cntrst", int'(tick_if.CntRst), 1);
    chk("arst_anim", int'(AnimFrame), 0);
    tick1();
    Rst_n = 1'b1;
    tick1();

    // March to the right edge: 66 steps reach X=280
    do_start();
    tick1();
    for (int i = 0; i < 66; i++) pulse_m2();
    chk("edge_posx", int'(PosX), 280);
    m2_step();
    chk("edge_hold_x", int'(PosX), 280);
    chk("edge_no_pulse", int'(StepPulse), 0);
    tick1();
    chk("desc_posy", int'(PosY), 48);
    chk("desc_dir", int'(Dir), 0);
    chk("desc_posx", int'(PosX), 280);
    chk("desc_pulse", int'(StepPulse), 1);
    tick1();
    m2_step();
    chk("left_step", int'(PosX), 276);
    tick1(); tick1();

    // Keep marching until the formation lands (bounded)
    for (int i = 0; i < 3000; i++) begin
      if (Landed) break;
      pulse_m2();
    end
    chk("land_reached", int'(Landed), 1);
    chk("land_posy", int'(PosY), 400);
    chk("land_cnten", int'(tick_if.CntEn), 0);
    pulse_m2();
    chk("land_m2_ignored_y", int'(PosY), 400);
    chk("land_still", int'(Landed), 1);
    do_start();
    chk("restart_posy", int'(PosY), 32);
    chk("restart_landed", int'(Landed), 0);
    chk("restart_posx", int'(PosX), 16);
    tick1();

    // Pause: strobes ignored, then resume without lost/duplicate steps
    EN = 1'b0;
    tick1();
    chk("pause_cnten", int'(tick_if.CntEn), 0);
    pulse_m2();
    pulse_m2();
    chk("pause_posx", int'(PosX), 16);
    EN = 1'b1;
    tick1();
    m2_step();
    chk("resume_posx", int'(PosX), 20);
    tick1(); tick1();
    AliveCnt = 6'd0;
    tick1();
    chk("clear_cntrst", int'(tick_if.CntRst), 1);
    chk("clear_cnten", int'(tick_if.CntEn), 0);
    AliveCnt = 6'd20;
    pulse_m2();
    chk("idle_m2_ignored", int'(PosX), 20);

    // M1 handling, with and without the speed-up feature
    do_start();
    tick1();
    AliveCnt = 6'd8;
    tick_if.M1 = 1'b1;
    tick1();
    tick_if.M1 = 1'b0;
    tick1();
    pulse_m2();
`ifdef SPEEDUP_EN
    x_exp = 24;
`else
    x_exp = 20;
`endif
    chk("m1_fast", int'(PosX), x_exp);
    AliveCnt = 6'd9;
    tick_if.M1 = 1'b1;
    tick1();
    tick_if.M1 = 1'b0;
    tick1();
    pulse_m2();
    chk("m1_slow", int'(PosX), x_exp + 4);
    AliveCnt = 6'd8;
    tick_if.M1 = 1'b1;
    tick_if.M2 = 1'b1;
    tick1();
    tick_if.M1 = 1'b0;
    tick_if.M2 = 1'b0;
    chk("m1m2_single", int'(PosX), x_exp + 8);
    tick1(); tick1();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
